// File: rtl/pa_fmau_mac_add_norm.sv
// pa_fmau_mac_add_norm: EX2 product/addend add with sign-magnitude fixup, EX3 register stage with leading-zero count
module pa_fmau_mac_add_norm (
  input  logic        forever_cpuclk,
  input  logic        cpurst_b,
  input  logic        ctrl_dp_ex2_inst_pipe_down,
  input  logic        ctrl_xx_ex2_warm_up,
  input  logic        ctrl_xx_ex2_flush,
  input  logic        ex3_stall,
  input  logic [47:0] ex2_mult_data,
  input  logic        ex2_mult_sign,
  input  logic [52:0] ex2_shift_data,
  input  logic        ex2_src2_sign,
  input  logic [9:0]  ex2_mac_expnt,
  input  logic        ex2_adder_0_sel_h,
  input  logic        ex2_mac,
  output logic        ex3_vld,
  output logic [52:0] ex3_sum,
  output logic        ex3_sign,
  output logic [9:0]  ex3_expnt,
  output logic [5:0]  ex3_lzc,
  output logic        ex3_sum_zero,
  output logic        ex3_adder_0_sel_h
);
  logic [52:0] op_p, op_a, ex2_sum, sum_d, sum_q;
  logic [53:0] raw;
  logic        eff_sub, neg, ex2_sign, cap;
  logic        vld_d, vld_q, sign_d, sign_q, sel_d, sel_q;
  logic [9:0]  expnt_d, expnt_q;
  // EX2: add or subtract the aligned addend, then turn a negative difference back into a magnitude
  always_comb begin
    op_p     = {3'b0, ex2_mult_data, 2'b0};
    op_a     = ex2_mac ? ex2_shift_data : 53'b0;
    eff_sub  = ex2_mac & (ex2_mult_sign ^ ex2_src2_sign);
    raw      = {1'b0, op_p} + (eff_sub ? (~{1'b0, op_a} + 54'd1) : {1'b0, op_a});
    neg      = eff_sub & raw[53];
    ex2_sum  = neg ? (~raw[52:0] + 53'd1) : raw[52:0];
    ex2_sign = ~|ex2_sum ? (ex2_mult_sign & ~eff_sub) : (neg ? ex2_src2_sign : ex2_mult_sign);
  end
  // EX3 next state: data captures on advance or warm-up unless stalled; valid follows flush/stall/advance priority
  always_comb begin
    cap     = (ctrl_dp_ex2_inst_pipe_down | ctrl_xx_ex2_warm_up) & ~ex3_stall;
    vld_d   = ctrl_xx_ex2_flush ? 1'b0 : (ex3_stall ? vld_q : ctrl_dp_ex2_inst_pipe_down);
    sum_d   = cap ? ex2_sum : sum_q;
    sign_d  = cap ? ex2_sign : sign_q;
    expnt_d = cap ? ex2_mac_expnt : expnt_q;
    sel_d   = cap ? ex2_adder_0_sel_h : sel_q;
  end
  // EX3 pipeline registers
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      vld_q   <= 1'b0;
      sum_q   <= 53'b0;
      sign_q  <= 1'b0;
      expnt_q <= 10'b0;
      sel_q   <= 1'b0;
    end else begin
      vld_q   <= vld_d;
      sum_q   <= sum_d;
      sign_q  <= sign_d;
      expnt_q <= expnt_d;
      sel_q   <= sel_d;
    end
  end
  // EX3 leading-zero count: the highest set bit wins, all-zero reads as 53
  always_comb begin
    ex3_lzc = 6'd53;
    for (int i = 0; i < 53; i++)
      if (sum_q[i]) ex3_lzc = 6'(52 - i);
  end
  assign ex3_vld           = vld_q;
  assign ex3_sum           = sum_q;
  assign ex3_sign          = sign_q;
  assign ex3_expnt         = expnt_q;
  assign ex3_sum_zero      = ~|sum_q;
  assign ex3_adder_0_sel_h = sel_q;
endmodule

// File: doc/pa_fmau_mac_add_norm.md
PA_FMAU_MAC_ADD_NORM -- requirements
Module: pa_fmau_mac_add_norm

Interface
REQ-001 The block SHALL use clock forever_cpuclk and reset cpurst_b: one clock; reset is asynchronous and active-low.
REQ-002 Port: forever_cpuclk  in  1  sole clock; all state rises on its posedge.
REQ-003 Port: cpurst_b  in  1  asynchronous active-low reset.
REQ-004 Port: ctrl_dp_ex2_inst_pipe_down  in  1  EX2 instruction advances to EX3 this cycle.
REQ-005 Port: ctrl_xx_ex2_warm_up  in  1  force data-register capture without creating a valid.
REQ-006 Port: ctrl_xx_ex2_flush  in  1  kill EX3 valid.
REQ-007 Port: ex3_stall  in  1  downstream (round) holds EX3.
REQ-008 Port: ex2_mult_data  in  48  unsigned 24x24 product magnitude.
REQ-009 Port: ex2_mult_sign  in  1  product sign.
REQ-010 Port: ex2_shift_data  in  53  aligned addend from the frac-shift stage.
REQ-011 Port: ex2_src2_sign  in  1  effective addend sign.
REQ-012 Port: ex2_mac_expnt  in  10  result exponent from the frac-shift stage.
REQ-013 Port: ex2_adder_0_sel_h / ex2_mac  in  1 each  addend-dominant flag / fused op flag.
REQ-014 Port outputs: ex3_vld 1, ex3_sum 53, ex3_sign 1, ex3_expnt 10, ex3_lzc 6, ex3_sum_zero 1, ex3_adder_0_sel_h 1.

Function
REQ-015 EX2 (comb): op_p = {3'b0, ex2_mult_data, 2'b0}; op_a = ex2_mac ? ex2_shift_data : 53'b0.
REQ-016 eff_sub = ex2_mac & (ex2_mult_sign ^ ex2_src2_sign).
REQ-017 raw[53:0] = {1'b0,op_p} + (eff_sub ? (~{1'b0,op_a} + 1) : {1'b0,op_a}), modulo 2^54.
REQ-018 If eff_sub & raw[53]: sum = (-raw)[52:0], sign = ex2_src2_sign; else sum = raw[52:0], sign = ex2_mult_sign.
REQ-019 Non-subtract carry into bit 53 SHALL not occur for legal inputs (op_p < 2^50, op_a < 2^53 guaranteed upstream); bit 53 is discarded.
REQ-020 Exact zero (sum == 0): sign = 0 when eff_sub, else ex2_mult_sign.
REQ-021 EX3 data regs (sum, sign, expnt, adder_0_sel_h) SHALL capture when (pipe_down | warm_up) & !ex3_stall; otherwise hold.
REQ-022 ex3_vld next: flush -> 0; else ex3_stall -> hold; else pipe_down -> 1; else -> 0.
REQ-023 Flush and pipe_down same cycle: ex3_vld = 0; data regs MAY update.
REQ-024 pipe_down while ex3_stall: stall wins, EX3 holds, EX2 op not lost (ctrl keeps it in EX2).
REQ-025 EX3 (comb from regs): ex3_lzc = count of leading zeros of ex3_sum[52:0], range 0..52; ex3_sum_zero = (ex3_sum == 0), then ex3_lzc = 53.
REQ-026 ex3_expnt = registered ex2_mac_expnt unmodified; normalization adjust belongs to round stage.
REQ-027 Latency: one cycle EX2 -> EX3 outputs; throughput one op per cycle when not stalled.
REQ-028 Outputs SHALL be functions of EX3 registers only (no EX2 comb paths to outputs).

Reset
REQ-029 On cpurst_b low, immediately: ex3_vld = 0, ex3_sum = 0, ex3_sign = 0, ex3_expnt = 0, ex3_adder_0_sel_h = 0; hence ex3_sum_zero = 1, ex3_lzc = 53.
REQ-030 Reset mid-operation SHALL discard the in-flight EX3 op; first post-reset pipe_down produces a normal result next cycle.
REQ-031 Warm_up alone SHALL never set ex3_vld.

Verification
REQ-032 mac=0, mult_data=0x400000000000, mult_sign=1, pipe_down -> next cycle ex3_vld=1, ex3_sum=0x1000000000000, ex3_sign=1, ex3_lzc=4.
REQ-033 mac=1, mult_data=0x400000000000, shift_data=0x1000000000000, mult_sign=0, src2_sign=1 -> ex3_sum=0, ex3_sum_zero=1, ex3_sign=0, ex3_lzc=53.
REQ-034 mac=1, same product, shift_data=0x1800000000000, mult_sign=0, src2_sign=1 -> ex3_sum=0x0800000000000, ex3_sign=1, ex3_lzc=5.
REQ-035 Op A captured, then ex3_stall=1 for 3 cycles with pipe_down=1 and new op B -> EX3 holds A all 3 cycles, vld=1; stall drop -> B captured next edge.
REQ-036 pipe_down=1 and flush=1 same cycle -> ex3_vld=0 next cycle; warm_up=1 alone -> data regs update, ex3_vld stays 0.
REQ-037 Assert cpurst_b=0 while ex3_vld=1 -> ex3_vld=0 and all EX3 regs 0 without waiting for a clock edge.
